bp_pht_update_ctrl: RTL and testbench
=====================================

# bp_pht_update_ctrl

Sequencer for the branch predictor's pattern/choice history tables: owns the single write port of a 2-bit saturating-counter table. After reset it sweeps every entry to weakly-not-taken, then serialises M-stage branch-resolution updates through a small FIFO. Each update is a read-modify-write against a synchronous-read RAM. It sits between the M-stage resolution logic and the table storage, replacing per-entry reset loops with a bounded, predictable init sequence.

## Interface
- IDX_W, 7, table index width (2^IDX_W entries)
- FIFO_DEPTH, 4, pending-update FIFO entries (power of two, ≥2)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- upd_valid  in  1  M-stage branch resolved; update requested
- upd_idx  in  IDX_W  table index of resolved branch
- upd_taken  in  1  resolved direction (1 = increment, 0 = decrement)
- upd_ready  out  1  FIFO not full; push occurs when upd_valid & upd_ready
- pht_raddr  out  IDX_W  update read address (synchronous RAM, 1-cycle latency)
- pht_re  out  1  read enable
- pht_rdata  in  2  counter read data, valid the cycle after pht_re
- pht_we  out  1  write enable
- pht_waddr  out  IDX_W  write address
- pht_wdata  out  2  write data
- init_done  out  1  table initialised; lookups are meaningful
- drop_pulse  out  1  upd_valid seen while FIFO full (update discarded)

## Operation
- FSM states: INIT, IDLE, RMW_RD, RMW_WR.
- INIT: pht_we=1, pht_waddr=init_cnt, pht_wdata=2'b01. init_cnt increments 0..2^IDX_W−1. After writing the last entry → IDLE. init_done=1 from the following cycle.
- FIFO accepts pushes during INIT. Updates drain only after INIT.
- IDLE: if FIFO non-empty, pop head, latch idx/taken, assert pht_re with pht_raddr=head.idx → RMW_RD. Otherwise stay.
- RMW_RD: pht_rdata arrives at end of cycle → RMW_WR.
- RMW_WR: pht_we=1, pht_waddr=latched idx, pht_wdata = sat(rdata ± 1). taken at 2'b11 stays 11; not-taken at 2'b00 stays 00. Then → IDLE.
- Same-index back-to-back updates need no bypass: the write commits before the next RMW_RD read is registered.
- FIFO full with upd_valid=1: update dropped, drop_pulse=1 for that cycle. The predictor is a hint, so no stall is generated.
- A push and a pop in the same cycle are both legal when the FIFO is neither full nor empty. upd_ready is computed from the registered count, not a same-cycle pop.

## Timing
- Reset values: state=INIT, init_cnt=0, FIFO empty, init_done=0, upd_ready=1, pht_re=0, drop_pulse=0, pht_raddr/pht_waddr/pht_wdata=0.
- During the first INIT cycle after reset release: pht_we=1, pht_waddr=0.
- INIT length: exactly 2^IDX_W cycles. For IDX_W=7, init_done rises on cycle 128 after reset deasserts.
- Update latency: push at edge N → pht_re in cycle N+1 → pht_we in cycle N+3 → committed at end of N+3.
- Throughput: one update per 3 cycles (IDLE, RMW_RD, RMW_WR).
- rst mid-operation (any state): abandon any RMW without writing, flush the FIFO, restart INIT at index 0.

## Configuration
- BP_UPD_STATS_EN defined:
  - adds 16-bit outputs upd_cnt (committed RMW writes) and drop_cnt (dropped updates), both saturating and cleared by rst.
- Undefined: those ports and counters are absent; drop_pulse remains.

## Structure
- bp_pkg holds:
  - typedef ctr2_t (logic [1:0])
  - constant CTR_INIT = 2'b01
  - FSM state enum
  - sat_inc/sat_dec functions (shareable with predictor lookup logic)
- One sub-module: bp_upd_fifo, a parameterised sync FIFO of {idx, taken} with full/empty/count.

## Test plan
- Reset release with IDX_W=7 → pht_we=1 for 128 consecutive cycles, waddr 0..127, wdata 01. init_done=1 on the next cycle.
- After init, push {idx=5, taken=1} with model rdata=01 → pht_re at addr 5 one cycle later; two cycles after that pht_we, addr 5, wdata 10.
- Saturation: rdata=11 with taken=1 → wdata 11; rdata=00 with taken=0 → wdata 00.
- Five pushes in consecutive cycles during INIT with FIFO_DEPTH=4 → 4 accepted, 5th gives drop_pulse=1. The 4 updates drain in order after init_done, one every 3 cycles.
- Two pushes to idx 9, both taken, starting at 01 → writes 10 then 11, with no lost increment.
- rst asserted during RMW_RD with FIFO holding 2 entries → no pht_we for that update, FIFO empty, INIT restarts at waddr 0.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared branch-predictor types: 2-bit counter, init value,
// update-sequencer FSM states and saturating counter helpers.
package bp_pkg;

    typedef logic [1:0] ctr2_t;

    localparam ctr2_t CTR_INIT = 2'b01;

    typedef enum logic [1:0] {
        ST_INIT,
        ST_IDLE,
        ST_RMW_RD,
        ST_RMW_WR
    } bp_upd_state_e;

    function automatic ctr2_t sat_inc(input ctr2_t c);
        return (c == 2'b11) ? c : c + 2'd1;
    endfunction

    function automatic ctr2_t sat_dec(input ctr2_t c);
        return (c == 2'b00) ? c : c - 2'd1;
    endfunction

endpackage

// File: rtl/bp_upd_fifo.sv
// Synchronous FIFO of pending PHT updates ({idx, taken} packed in W bits).
// Ports: clk, rst (sync, active-high), push/wdata, pop/rdata, full, empty, count.
module bp_upd_fifo
    import bp_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [W-1:0]     wdata,
    input  logic             pop,
    output logic [W-1:0]     rdata,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [W-1:0]     mem_q [DEPTH];
    logic [W-1:0]     mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage needs no reset: entries are only read when count says valid.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/bp_pht_update_ctrl.sv
// Sole write-port owner of the 2-bit PHT: sweeps all entries to weakly-not-taken
// after reset, then serialises queued branch-resolution updates as
// read-modify-write sequences against a 1-cycle synchronous-read RAM.
// Ports: clk, rst (sync, active-high); upd_valid/upd_idx/upd_taken/upd_ready
// (update push); pht_re/pht_raddr/pht_rdata (RAM read); pht_we/pht_waddr/
// pht_wdata (RAM write); init_done; drop_pulse (update lost, FIFO full).
// Macro BP_UPD_STATS_EN adds saturating 16-bit counters upd_cnt and drop_cnt.
module bp_pht_update_ctrl
    import bp_pkg::*;
#(
    parameter int IDX_W      = 7,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             upd_valid,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic             upd_taken,
    output logic             upd_ready,
    output logic [IDX_W-1:0] pht_raddr,
    output logic             pht_re,
    input  ctr2_t            pht_rdata,
    output logic             pht_we,
    output logic [IDX_W-1:0] pht_waddr,
    output ctr2_t            pht_wdata,
    output logic             init_done,
    output logic             drop_pulse
`ifdef BP_UPD_STATS_EN
    ,
    output logic [15:0]      upd_cnt,
    output logic [15:0]      drop_cnt
`endif
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    bp_upd_state_e    state_q, state_d;
    logic [IDX_W-1:0] init_cnt_q, init_cnt_d;
    logic [IDX_W-1:0] lat_idx_q, lat_idx_d;
    logic             lat_taken_q, lat_taken_d;
    ctr2_t            rdata_q, rdata_d;

    logic             fifo_push, fifo_pop;
    logic [IDX_W:0]   fifo_rdata;
    logic             fifo_full, fifo_empty;
    logic [CNT_W-1:0] fifo_count;

    // Readiness comes from the registered count only; a same-cycle pop
    // does not free a slot for this cycle's push.
    assign upd_ready  = rst || (fifo_count < CNT_W'(FIFO_DEPTH));
    assign fifo_push  = !rst && upd_valid && upd_ready;
    assign drop_pulse = !rst && upd_valid && fifo_full;
    assign init_done  = !rst && (state_q != ST_INIT);

    bp_upd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (IDX_W + 1)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .wdata ({upd_idx, upd_taken}),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        state_d     = state_q;
        init_cnt_d  = init_cnt_q;
        lat_idx_d   = lat_idx_q;
        lat_taken_d = lat_taken_q;
        rdata_d     = rdata_q;
        fifo_pop    = 1'b0;
        pht_re      = 1'b0;
        pht_raddr   = '0;
        pht_we      = 1'b0;
        pht_waddr   = '0;
        pht_wdata   = '0;

        unique case (state_q)
            ST_INIT: begin
                pht_we     = 1'b1;
                pht_waddr  = init_cnt_q;
                pht_wdata  = CTR_INIT;
                init_cnt_d = init_cnt_q + IDX_W'(1);
                if (init_cnt_q == '1) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop    = 1'b1;
                    pht_re      = 1'b1;
                    pht_raddr   = fifo_rdata[IDX_W:1];
                    lat_idx_d   = fifo_rdata[IDX_W:1];
                    lat_taken_d = fifo_rdata[0];
                    state_d     = ST_RMW_RD;
                end
            end
            ST_RMW_RD: begin
                // RAM data for the read issued in IDLE is valid now.
                rdata_d = pht_rdata;
                state_d = ST_RMW_WR;
            end
            ST_RMW_WR: begin
                pht_we    = 1'b1;
                pht_waddr = lat_idx_q;
                pht_wdata = lat_taken_q ? sat_inc(rdata_q) : sat_dec(rdata_q);
                state_d   = ST_IDLE;
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase

        // Reset abandons any in-flight RMW without touching the table.
        if (rst) begin
            fifo_pop  = 1'b0;
            pht_re    = 1'b0;
            pht_raddr = '0;
            pht_we    = 1'b0;
            pht_waddr = '0;
            pht_wdata = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_INIT;
            init_cnt_q  <= '0;
            lat_idx_q   <= '0;
            lat_taken_q <= 1'b0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            init_cnt_q  <= init_cnt_d;
            lat_idx_q   <= lat_idx_d;
            lat_taken_q <= lat_taken_d;
            rdata_q     <= rdata_d;
        end
    end

`ifdef BP_UPD_STATS_EN
    logic [15:0] upd_cnt_q, upd_cnt_d;
    logic [15:0] drop_cnt_q, drop_cnt_d;
    logic        commit;

    assign commit = pht_we && (state_q == ST_RMW_WR);

    always_comb begin
        upd_cnt_d  = upd_cnt_q;
        drop_cnt_d = drop_cnt_q;
        if (commit && (upd_cnt_q != '1)) begin
            upd_cnt_d = upd_cnt_q + 16'd1;
        end
        if (drop_pulse && (drop_cnt_q != '1)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            upd_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            upd_cnt_q  <= upd_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign upd_cnt  = upd_cnt_q;
    assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_bp_pht_update_ctrl.sv
// Directed, table-driven bench for bp_pht_update_ctrl with a behavioural
// 1-cycle synchronous-read RAM standing in for the PHT storage.
module tb_bp_pht_update_ctrl;

    localparam int IDX_W = 7;
    localparam int DEPTH = 4;

    logic             clk;
    logic             rst;
    logic             upd_valid;
    logic [IDX_W-1:0] upd_idx;
    logic             upd_taken;
    logic             upd_ready;
    logic [IDX_W-1:0] pht_raddr;
    logic             pht_re;
    logic [1:0]       pht_rdata;
    logic             pht_we;
    logic [IDX_W-1:0] pht_waddr;
    logic [1:0]       pht_wdata;
    logic             init_done;
    logic             drop_pulse;
`ifdef BP_UPD_STATS_EN
    logic [15:0]      upd_cnt;
    logic [15:0]      drop_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    bp_pht_update_ctrl #(
        .IDX_W      (IDX_W),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .upd_valid  (upd_valid),
        .upd_idx    (upd_idx),
        .upd_taken  (upd_taken),
        .upd_ready  (upd_ready),
        .pht_raddr  (pht_raddr),
        .pht_re     (pht_re),
        .pht_rdata  (pht_rdata),
        .pht_we     (pht_we),
        .pht_waddr  (pht_waddr),
        .pht_wdata  (pht_wdata),
        .init_done  (init_done),
        .drop_pulse (drop_pulse)
`ifdef BP_UPD_STATS_EN
        ,
        .upd_cnt    (upd_cnt),
        .drop_cnt   (drop_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0] ram [1 << IDX_W];
    always @(posedge clk) begin
        if (pht_we) ram[pht_waddr] <= pht_wdata;
        if (pht_re) pht_rdata <= ram[pht_raddr];
    end

    typedef struct {
        logic [IDX_W-1:0] idx;
        logic             taken;
        logic [1:0]       exp_wd;
    } vec_t;

    vec_t vecs [10];
    vec_t cvec [5];

    task automatic chkv(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_bus(input string nm, input logic re, input logic [IDX_W-1:0] ra,
                           input logic we, input logic [IDX_W-1:0] wa, input logic [1:0] wd);
        chkv({nm, ".re"}, 8'(pht_re), 8'(re));
        chkv({nm, ".raddr"}, 8'(pht_raddr), 8'(ra));
        chkv({nm, ".we"}, 8'(pht_we), 8'(we));
        chkv({nm, ".waddr"}, 8'(pht_waddr), 8'(wa));
        chkv({nm, ".wdata"}, 8'(pht_wdata), 8'(wd));
    endtask

    task automatic drv(input logic v, input logic [IDX_W-1:0] idx, input logic t);
        upd_valid = v;
        upd_idx   = idx;
        upd_taken = t;
    endtask

    // Leaves the bench at the negedge where rst drops: INIT cycle 0 begins.
    task automatic do_reset();
        rst = 1'b1;
        drv(1'b0, '0, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic got;

        vecs[0] = '{7'd5,   1'b1, 2'b10};
        vecs[1] = '{7'd9,   1'b1, 2'b10};
        vecs[2] = '{7'd9,   1'b1, 2'b11};
        vecs[3] = '{7'd9,   1'b1, 2'b11};
        vecs[4] = '{7'd20,  1'b0, 2'b00};
        vecs[5] = '{7'd20,  1'b0, 2'b00};
        vecs[6] = '{7'd20,  1'b1, 2'b01};
        vecs[7] = '{7'd127, 1'b1, 2'b10};
        vecs[8] = '{7'd0,   1'b0, 2'b00};
        vecs[9] = '{7'd5,   1'b0, 2'b01};

        cvec[0] = '{7'd10, 1'b1, 2'b10};
        cvec[1] = '{7'd11, 1'b0, 2'b00};
        cvec[2] = '{7'd12, 1'b1, 2'b10};
        cvec[3] = '{7'd13, 1'b0, 2'b00};
        cvec[4] = '{7'd14, 1'b1, 2'b10};

        // Reset state and full init sweep.
        rst = 1'b1;
        drv(1'b0, '0, 1'b0);
        repeat (3) @(negedge clk);
        #1;
        chk_bus("rst", 1'b0, '0, 1'b0, '0, 2'b00);
        chkv("rst.init_done", 8'(init_done), 8'd0);
        chkv("rst.upd_ready", 8'(upd_ready), 8'd1);
        chkv("rst.drop", 8'(drop_pulse), 8'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        for (int i = 0; i < (1 << IDX_W); i++) begin
            chk_bus($sformatf("init%0d", i), 1'b0, '0, 1'b1, IDX_W'(i), 2'b01);
            chkv("init.done_low", 8'(init_done), 8'd0);
            @(negedge clk);
            #1;
        end
        chkv("init.done_high", 8'(init_done), 8'd1);
        chk_bus("idle_after_init", 1'b0, '0, 1'b0, '0, 2'b00);

        // Single isolated updates: push, read 1 cycle later, write 2 after that.
        for (int v = 0; v < 10; v++) begin
            @(negedge clk);
            drv(1'b1, vecs[v].idx, vecs[v].taken);
            #1;
            chkv($sformatf("v%0d.ready", v), 8'(upd_ready), 8'd1);
            chk_bus($sformatf("v%0d.push", v), 1'b0, '0, 1'b0, '0, 2'b00);
            @(negedge clk);
            drv(1'b0, '0, 1'b0);
            #1;
            chk_bus($sformatf("v%0d.rd", v), 1'b1, vecs[v].idx, 1'b0, '0, 2'b00);
            @(negedge clk);
            #1;
            chk_bus($sformatf("v%0d.wait", v), 1'b0, '0, 1'b0, '0, 2'b00);
            @(negedge clk);
            #1;
            chk_bus($sformatf("v%0d.wr", v), 1'b0, '0, 1'b1, vecs[v].idx, vecs[v].exp_wd);
        end

        // Five pushes during INIT: four queued, fifth dropped.
        @(negedge clk);
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drv(1'b1, cvec[i].idx, cvec[i].taken);
            #1;
            chkv($sformatf("c%0d.ready", i), 8'(upd_ready), (i < 4) ? 8'd1 : 8'd0);
            chkv($sformatf("c%0d.drop", i), 8'(drop_pulse), (i < 4) ? 8'd0 : 8'd1);
            chk_bus($sformatf("c%0d.init", i), 1'b0, '0, 1'b1, IDX_W'(i), 2'b01);
            @(negedge clk);
        end
        drv(1'b0, '0, 1'b0);
        got = 1'b0;
        for (int t = 0; t < 200; t++) begin
            #1;
            if (init_done) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chkv("c.init_wait", 8'(got), 8'd1);
        for (int k = 0; k < 4; k++) begin
            chk_bus($sformatf("c%0d.rd", k), 1'b1, cvec[k].idx, 1'b0, '0, 2'b00);
            @(negedge clk);
            #1;
            @(negedge clk);
            #1;
            chk_bus($sformatf("c%0d.wr", k), 1'b0, '0, 1'b1, cvec[k].idx, cvec[k].exp_wd);
            @(negedge clk);
            #1;
        end
        for (int k = 0; k < 3; k++) begin
            chk_bus($sformatf("c.quiet%0d", k), 1'b0, '0, 1'b0, '0, 2'b00);
            @(negedge clk);
            #1;
        end

        // Back-to-back same-index increments must both land.
        @(negedge clk);
        drv(1'b1, 7'd9, 1'b1);
        #1;
        @(negedge clk);
        drv(1'b1, 7'd9, 1'b1);
        #1;
        chk_bus("e.rd0", 1'b1, 7'd9, 1'b0, '0, 2'b00);
        @(negedge clk);
        drv(1'b0, '0, 1'b0);
        #1;
        @(negedge clk);
        #1;
        chk_bus("e.wr0", 1'b0, '0, 1'b1, 7'd9, 2'b10);
        @(negedge clk);
        #1;
        chk_bus("e.rd1", 1'b1, 7'd9, 1'b0, '0, 2'b00);
        @(negedge clk);
        #1;
        @(negedge clk);
        #1;
        chk_bus("e.wr1", 1'b0, '0, 1'b1, 7'd9, 2'b11);

        // Reset while in RMW_RD with two entries still queued.
        @(negedge clk);
        drv(1'b1, 7'd30, 1'b1);
        #1;
        chkv("d.ready", 8'(upd_ready), 8'd1);
        @(negedge clk);
        drv(1'b1, 7'd31, 1'b1);
        #1;
        chk_bus("d.rd30", 1'b1, 7'd30, 1'b0, '0, 2'b00);
        @(negedge clk);
        drv(1'b1, 7'd32, 1'b1);
        #1;
        @(negedge clk);
        drv(1'b1, 7'd33, 1'b1);
        #1;
        chk_bus("d.wr30", 1'b0, '0, 1'b1, 7'd30, 2'b10);
        @(negedge clk);
        drv(1'b0, '0, 1'b0);
        #1;
        chk_bus("d.rd31", 1'b1, 7'd31, 1'b0, '0, 2'b00);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk_bus("d.rst_rd", 1'b0, '0, 1'b0, '0, 2'b00);
        chkv("d.rst_ready", 8'(upd_ready), 8'd1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk_bus("d.init0", 1'b0, '0, 1'b1, 7'd0, 2'b01);
        chkv("d.init_done0", 8'(init_done), 8'd0);
        for (int i = 1; i < (1 << IDX_W); i++) begin
            @(negedge clk);
            #1;
        end
        chk_bus("d.init_last", 1'b0, '0, 1'b1, 7'd127, 2'b01);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #1;
            chk_bus($sformatf("d.flushed%0d", k), 1'b0, '0, 1'b0, '0, 2'b00);
            chkv($sformatf("d.done%0d", k), 8'(init_done), 8'd1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
